pc_fetch_unit: RTL

- Program-counter and instruction-fetch stage of the 32-bit processor.
- Holds the PC and drives a req/ack instruction-memory request.
- Produces pc_plus_step, which feeds the next-PC 2:1 mux on its sel=0 input; the branch target feeds sel=1.
- Consumes the mux output as next_pc, with mux sel tied to redirect.
- Presents the fetched instruction to decode with a valid/stall handshake.

---
 rtl/proc_pkg.sv | 15 +
 rtl/pc_fetch_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/proc_pkg.sv
// Shared processor definitions: datapath width, PC defaults and the
// fetch-stage state encoding.
package proc_pkg;

  localparam int unsigned DEFAULT_DATA_LENGTH = 32;
  localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_PC_STEP     = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit.sv
// PC register and instruction-fetch stage: issues req/ack fetches at pc,
// squashes wrong-path words and presents good ones to decode.
module pc_fetch_unit
  import proc_pkg::*;
#(
  parameter int unsigned                DATA_LENGTH = DEFAULT_DATA_LENGTH,
  parameter logic [DATA_LENGTH-1:0]     RESET_PC    = DATA_LENGTH'(DEFAULT_RESET_PC),
  parameter logic [DATA_LENGTH-1:0]     PC_STEP     = DATA_LENGTH'(DEFAULT_PC_STEP)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   redirect,
  input  logic [DATA_LENGTH-1:0] next_pc,
  input  logic                   imem_ack,
  input  logic [DATA_LENGTH-1:0] imem_rdata,
  output logic                   imem_req,
  output logic [DATA_LENGTH-1:0] imem_addr,
  output logic [DATA_LENGTH-1:0] pc,
  output logic [DATA_LENGTH-1:0] pc_plus_step,
  output logic [DATA_LENGTH-1:0] instr,
  output logic [DATA_LENGTH-1:0] instr_pc,
  output logic                   instr_valid
);

  fetch_state_e           state_q, state_d;
  logic [DATA_LENGTH-1:0] pc_q, pc_d;
  logic [DATA_LENGTH-1:0] instr_q, instr_d;
  logic [DATA_LENGTH-1:0] instr_pc_q, instr_pc_d;
  logic [DATA_LENGTH-1:0] redirect_pc_q, redirect_pc_d;
  logic                   instr_valid_q, instr_valid_d;
  logic                   imem_req_q, imem_req_d;
  logic                   kill_q, kill_d;
  logic                   redirect_pending_q, redirect_pending_d;

  assign pc_plus_step = pc_q + PC_STEP;
  assign pc           = pc_q;
  assign imem_addr    = pc_q;
  assign imem_req     = imem_req_q;
  assign instr        = instr_q;
  assign instr_pc     = instr_pc_q;
  assign instr_valid  = instr_valid_q;

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    instr_d            = instr_q;
    instr_pc_d         = instr_pc_q;
    redirect_pc_d      = redirect_pc_q;
    instr_valid_d      = instr_valid_q;
    imem_req_d         = imem_req_q;
    kill_d             = kill_q;
    redirect_pending_d = redirect_pending_q;

    case (state_q)
      S_IDLE: begin
        state_d    = S_REQ;
        imem_req_d = 1'b1;
        if (redirect) begin
          pc_d = next_pc;
        end
      end

      S_REQ: begin
        if (imem_ack) begin
          // A redirect seen while waiting overrides the sequential next_pc,
          // unless a fresh redirect arrives together with the ack.
          pc_d               = redirect ? next_pc
                             : (redirect_pending_q ? redirect_pc_q : next_pc);
          kill_d             = 1'b0;
          redirect_pending_d = 1'b0;
          if (kill_q || redirect) begin
            state_d    = S_REQ;
            imem_req_d = 1'b1;
          end else begin
            instr_d       = imem_rdata;
            instr_pc_d    = pc_q;
            instr_valid_d = 1'b1;
            state_d       = S_HOLD;
            imem_req_d    = 1'b0;
          end
        end else if (redirect) begin
          redirect_pc_d      = next_pc;
          redirect_pending_d = 1'b1;
          kill_d             = 1'b1;
        end
      end

      S_HOLD: begin
        if (redirect) begin
          instr_valid_d = 1'b0;
          pc_d          = next_pc;
          state_d       = S_REQ;
          imem_req_d    = 1'b1;
        end else if (!stall) begin
          instr_valid_d = 1'b0;
          state_d       = S_REQ;
          imem_req_d    = 1'b1;
        end
      end

      default: begin
        state_d       = S_IDLE;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q            <= S_IDLE;
      pc_q               <= RESET_PC;
      instr_q            <= '0;
      instr_pc_q         <= '0;
      redirect_pc_q      <= '0;
      instr_valid_q      <= 1'b0;
      imem_req_q         <= 1'b0;
      kill_q             <= 1'b0;
      redirect_pending_q <= 1'b0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      instr_q            <= instr_d;
      instr_pc_q         <= instr_pc_d;
      redirect_pc_q      <= redirect_pc_d;
      instr_valid_q      <= instr_valid_d;
      imem_req_q         <= imem_req_d;
      kill_q             <= kill_d;
      redirect_pending_q <= redirect_pending_d;
    end
  end

endmodule
